// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter in front of one shared 4-bit serial pattern detector.
// Define SEQ_DET_OVERLAP_EN for overlapping detection (default: non-overlapping).
module seq_det_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] pattern,
  input  logic       bit_in,
  input  logic       bit_vld,
  input  logic       bit_last,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       det,
  output logic       done,
  output logic       abort,
  output logic [1:0] done_id,
  output logic [7:0] match_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] pat_q, pat_d;
  logic [2:0] hist_q, hist_d;
  logic [1:0] hcnt_q, hcnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic       abt_q, abt_d;
  logic [1:0] did_q, did_d;
  logic [7:0] mcnt_q, mcnt_d;

  logic [1:0] win;
  logic [1:0] cand;
  logic       found;
  logic       last_bit;
  logic       drop;
  logic       in_run;
  logic       hit;

  always_comb begin
    win   = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign last_bit = bit_vld & bit_last;
  assign in_run   = (state_q == S_RUN);
  // Losing the request aborts unless the final bit arrives the same cycle.
  assign drop     = ~req[idx_q] & ~last_bit;
  assign hit      = (hcnt_q == 2'd3) && ({hist_q, bit_in} == pat_q);
  assign det      = in_run & bit_vld & ~drop & hit;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    hcnt_d  = hcnt_q;
    cnt_d   = cnt_q;
    abt_d   = abt_q;
    did_d   = did_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = 4'd1 << win;
          idx_d   = win;
          pat_d   = pattern;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        hist_d  = 3'd0;
        hcnt_d  = 2'd0;
        cnt_d   = 8'd0;
        abt_d   = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (drop) begin
          abt_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          if (bit_vld) begin
            hist_d = {hist_q[1:0], bit_in};
`ifdef SEQ_DET_OVERLAP_EN
            hcnt_d = (hcnt_q == 2'd3) ? 2'd3 : hcnt_q + 2'd1;
`else
            if (det)
              hcnt_d = 2'd0;
            else
              hcnt_d = (hcnt_q == 2'd3) ? 2'd3 : hcnt_q + 2'd1;
`endif
          end
          if (det && cnt_q != 8'hff)
            cnt_d = cnt_q + 8'd1;
          if (last_bit)
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        mcnt_d  = cnt_q;
        did_d   = idx_q;
        ptr_d   = idx_q;
        gnt_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'd0;
      idx_q   <= 2'd0;
      ptr_q   <= 2'd3;
      pat_q   <= 4'd0;
      hist_q  <= 3'd0;
      hcnt_q  <= 2'd0;
      cnt_q   <= 8'd0;
      abt_q   <= 1'b0;
      did_q   <= 2'd0;
      mcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      hcnt_q  <= hcnt_d;
      cnt_q   <= cnt_d;
      abt_q   <= abt_d;
      did_q   <= did_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE) & ~abt_q;
  assign abort     = (state_q == S_DONE) & abt_q;
  assign done_id   = did_q;
  assign match_cnt = mcnt_q;

endmodule
